// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch PC sequencer. It issues one instruction-memory request at a
// time, tracks the address of the outstanding request, and hands fetched
// instructions to decode through a single output register that can be held by
// a decode stall. Taken branches and jumps redirect the PC. A response that is
// already in flight when a redirect arrives is thrown away. Redirect targets
// that are not word aligned are rejected and flagged.
//
// Ports
//   clk, rst        : single clock, asynchronous active-high reset
//   branch_taken    : branch comparator result (qualified by br_valid)
//   br_valid        : a conditional branch resolves this cycle
//   br_target       : branch target address
//   jump            : unconditional jump resolves this cycle (wins over branch)
//   jump_target     : jump target address
//   stall           : decode cannot accept; hold the output register
//   imem_req        : instruction memory request
//   imem_addr       : request address (current pc)
//   imem_ready      : memory accepts the request this cycle
//   imem_rvalid     : read data valid
//   imem_rdata      : read data
//   if_valid        : if_pc / if_instr hold a valid fetched instruction
//   if_pc           : PC of the held instruction
//   if_instr        : held instruction (NOP_INSTR when nothing is held)
//   misaligned      : one-cycle pulse, redirect target had addr[1:0] != 0
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] inflight_pc;
    logic [31:0] inflight_nxt;
    logic        if_valid_nxt;
    logic [31:0] if_pc_nxt;
    logic [31:0] if_instr_nxt;

    logic        redir_req;
    logic [31:0] target;
    logic        target_ok;
    logic        redirect;
    logic        rsp_take;

    // Word alignment check for redirect targets.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Sequential next-fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_incr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // Redirect decode: jump wins over a taken branch when both resolve
    // together. A misaligned target kills the redirect completely.
    assign redir_req = jump | (br_valid & branch_taken);
    assign target    = jump ? jump_target : br_target;
    assign target_ok = is_aligned(target);
    assign redirect  = redir_req & target_ok;

    // Gated by rst so the pulse stays low while reset is held, even though
    // the redirect inputs are not under the block's control.
    assign misaligned = redir_req & ~target_ok & ~rst;

    // No new request while decode is holding a valid instruction, otherwise
    // the response could land on top of the held one.
    assign imem_req  = (state == REQ) & ~redirect & ~(if_valid & stall);
    assign imem_addr = pc;

    // A response is only consumed in WAIT; in REQ/BOOT it is stray and in
    // DROP it belongs to a flushed request.
    assign rsp_take = (state == WAIT) & imem_rvalid & ~redirect;

    // -------------------------------------------------------------------------
    // Next-state and PC logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inflight_nxt = inflight_pc;

        case (state)
            BOOT: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (imem_req && imem_ready) begin
                    state_nxt    = WAIT;
                    inflight_nxt = pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // Response arriving together with the redirect is simply
                    // not used; otherwise wait it out in DROP.
                    state_nxt = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    state_nxt = REQ;
                    pc_nxt    = pc_incr(inflight_pc);
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase

        // Redirect target overrides any sequential update in every state.
        if (redirect) begin
            pc_nxt = target;
        end
    end

    // -------------------------------------------------------------------------
    // Output register next values
    // -------------------------------------------------------------------------
    // A request is only issued when the output register is empty or being
    // drained this cycle, so in WAIT if_valid is always 0 and loading a
    // response can never overwrite an instruction held by stall.
    always_comb begin
        if_valid_nxt = if_valid;
        if_pc_nxt    = if_pc;
        if_instr_nxt = if_instr;

        if (redirect) begin
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP_INSTR;
        end else if (rsp_take) begin
            if_valid_nxt = 1'b1;
            if_pc_nxt    = inflight_pc;
            if_instr_nxt = imem_rdata;
        end else if (if_valid && !stall) begin
            // Decode consumed the instruction and nothing new arrived.
            if_valid_nxt = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inflight_pc <= inflight_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_instr <= NOP_INSTR;
        end else begin
            if_valid <= if_valid_nxt;
            if_pc    <= if_pc_nxt;
            if_instr <= if_instr_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit. A small memory model answers accepted
// requests after a programmable latency. Each scenario pushes the request
// addresses and fetched PCs it expects; they are popped and compared when the
// DUT issues a request or presents a new instruction.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic        br_valid;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misaligned;

    fetch_pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .misaligned   (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_out_q[$];

    // memory model state
    int          mem_lat  = 1;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt = 0;
    logic        inject   = 1'b0;
    logic        exp_mis  = 1'b0;
    logic        prev_v   = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_req_q.push_back(a);
        exp_out_q.push_back(a);
    endtask

    // One clock: sample request side before the edge, then the output side
    // and the memory model after it. Returns at the following negedge.
    task automatic step();
        logic [31:0] e;
        #1;
        chk("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
        if (imem_req && imem_ready) begin
            chk("req_expected", {31'd0, exp_req_q.size() != 0}, 32'd1);
            if (exp_req_q.size() != 0) begin
                e = exp_req_q.pop_front();
                chk("imem_addr", imem_addr, e);
            end
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        if (if_valid && !prev_v) begin
            chk("out_expected", {31'd0, exp_out_q.size() != 0}, 32'd1);
            if (exp_out_q.size() != 0) begin
                e = exp_out_q.pop_front();
                chk("if_pc", if_pc, e);
                chk("if_instr", if_instr, instr_of(e));
            end
        end
        prev_v = if_valid;
        imem_rvalid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend_addr);
                pend        = 1'b0;
            end
        end
        if (inject) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
    endtask

    task automatic fetch_seq(input int n);
        imem_ready = 1'b1;
        repeat (2 * n) step();
        imem_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_if_instr"}, if_instr, NOP);
        chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
        chk({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; branch_taken = 1'b0; br_valid = 1'b0; br_target = '0;
        jump = 1'b0; jump_target = '0; stall = 1'b0; imem_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        // Asynchronous reset, checked before any clock edge; a misaligned jump
        // presented during reset must not pulse misaligned.
        #2 rst = 1'b1;
        jump = 1'b1; jump_target = 32'h0000_0102;
        #1 chk_reset_vals("rst");
        jump = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b1;

        // Boot: no request in the first cycle, then 0x0, 0x4, 0x8
        #1 chk("boot_no_req", {31'd0, imem_req}, 32'd0);
        step();
        expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
        fetch_seq(3);

        // Not-taken branch: no flush
        br_valid = 1'b1; branch_taken = 1'b0; br_target = 32'h100;
        expect_fetch(32'hC); expect_fetch(32'h10);
        fetch_seq(2);
        br_valid = 1'b0;

        // Taken branch in WAIT, response two cycles later is dropped
        mem_lat = 2;
        exp_req_q.push_back(32'h14);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        br_valid = 1'b1; branch_taken = 1'b1; br_target = 32'h100;
        step();
        br_valid = 1'b0; branch_taken = 1'b0;
        chk("flush_if_valid", {31'd0, if_valid}, 32'd0);
        chk("flush_if_instr", if_instr, NOP);
        step();
        chk("drop_addr", imem_addr, 32'h100);
        mem_lat = 1;
        expect_fetch(32'h100);
        fetch_seq(1);

        // Jump and taken branch together in REQ: jump wins, no request
        jump = 1'b1; jump_target = 32'h200;
        br_valid = 1'b1; branch_taken = 1'b1; br_target = 32'h300;
        imem_ready = 1'b1;
        #1 chk("redir_no_req", {31'd0, imem_req}, 32'd0);
        step();
        jump = 1'b0; br_valid = 1'b0; branch_taken = 1'b0;
        imem_ready = 1'b0;
        expect_fetch(32'h200);
        fetch_seq(1);

        // Redirect in WAIT together with rvalid: response discarded
        exp_req_q.push_back(32'h204);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        jump = 1'b1; jump_target = 32'h400;
        step();
        jump = 1'b0;
        chk("wait_rv_discard", {31'd0, if_valid}, 32'd0);
        expect_fetch(32'h400);
        fetch_seq(1);

        // Misaligned jump in REQ and misaligned branch in WAIT: ignored
        jump = 1'b1; jump_target = 32'h102; exp_mis = 1'b1;
        imem_ready = 1'b1;
        expect_fetch(32'h404);
        step();
        jump = 1'b0;
        imem_ready = 1'b0;
        br_valid = 1'b1; branch_taken = 1'b1; br_target = 32'h301;
        step();
        br_valid = 1'b0; branch_taken = 1'b0; exp_mis = 1'b0;
        expect_fetch(32'h408);
        fetch_seq(1);

        // Stall with a valid instruction: no request, output held
        stall = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
            chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_if_pc", if_pc, 32'h408);
            chk("stall_if_instr", if_instr, instr_of(32'h408));
            step();
        end
        stall = 1'b0;
        expect_fetch(32'h40C);
        fetch_seq(1);

        // Redirect overrides stall
        stall = 1'b1;
        jump = 1'b1; jump_target = 32'h500;
        step();
        jump = 1'b0;
        chk("stall_redir_valid", {31'd0, if_valid}, 32'd0);
        chk("stall_redir_instr", if_instr, NOP);
        expect_fetch(32'h500);
        fetch_seq(1);
        stall = 1'b0;

        // 32-bit PC wrap
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        expect_fetch(32'hFFFF_FFFC); expect_fetch(32'h0);
        fetch_seq(2);

        // Reset mid-fetch; stray responses after release are ignored
        mem_lat = 2;
        exp_req_q.push_back(32'h4);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        rst = 1'b1;
        #1 chk_reset_vals("midrst");
        step();
        rst = 1'b0;
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        chk("stray_ignored", {31'd0, if_valid}, 32'd0);
        mem_lat = 1;
        expect_fetch(32'h0);
        fetch_seq(1);

        chk("req_q_drained", exp_req_q.size(), 32'd0);
        chk("out_q_drained", exp_out_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameters SHALL be:
  RESET_PC, 32'h0000_0000, first fetch address after reset.
  NOP_INSTR, 32'h0000_0013, value of if_instr when no instruction is held.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  input  1  single clock; all state on rising edge.
  rst  input  1  asynchronous, active-high reset.
  branch_taken  input  1  branch comparator result; meaningful only when br_valid=1.
  br_valid  input  1  conditional branch resolving this cycle.
  br_target  input  32  branch target address.
  jump  input  1  unconditional jump (jal/jalr) resolving this cycle.
  jump_target  input  32  jump target address.
  stall  input  1  decode cannot accept; holds the output register.
  imem_req  output  1  instruction memory request.
  imem_addr  output  32  request address.
  imem_ready  input  1  memory accepts the request this cycle.
  imem_rvalid  input  1  read data valid.
  imem_rdata  input  32  read data.
  if_valid  output  1  if_pc/if_instr hold a valid fetched instruction.
  if_pc  output  32  PC of the held instruction.
  if_instr  output  32  held instruction.
  misaligned  output  1  one-cycle pulse: redirect target had addr[1:0]!=0.
REQ-003 The clock and reset SHALL be the single clock clk and the asynchronous active-high reset rst.

Function
REQ-004 The block SHALL be a 4-state FSM: BOOT, REQ, WAIT, DROP; it SHALL hold a 32-bit pc register and a 32-bit inflight_pc register.
REQ-005 redirect SHALL be ((jump) | (br_valid & branch_taken)) & aligned target; jump has priority, so target = jump ? jump_target : br_target.
REQ-006 A target with addr[1:0]!=0 SHALL suppress the redirect entirely, assert misaligned for that one cycle, and leave pc and state unchanged.
REQ-007 Transitions:
  BOOT -> REQ: unconditionally, on the first clock after reset is released.
  REQ -> WAIT: when imem_req=1 and imem_ready=1; inflight_pc <= pc.
  WAIT -> REQ: on imem_rvalid.
  WAIT -> DROP: on redirect without imem_rvalid.
  DROP -> REQ: on imem_rvalid; the data SHALL be discarded.
REQ-008 imem_req SHALL be asserted only when all of the following hold: state=REQ, no redirect this cycle, and not (if_valid & stall).
REQ-009 imem_addr SHALL be pc (combinational).
REQ-010 In WAIT with imem_rvalid and no redirect, the block SHALL set if_valid<=1, if_instr<=imem_rdata and if_pc<=inflight_pc, and SHALL set pc<=inflight_pc+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0).
REQ-011 On redirect:
  pc SHALL become the target.
  if_valid SHALL clear next cycle and if_instr SHALL become NOP_INSTR.
  In REQ, the state SHALL stay REQ.
  In WAIT with imem_rvalid in the same cycle, the response SHALL be discarded and the state SHALL become REQ.
  In WAIT without imem_rvalid, the state SHALL become DROP.
  In DROP, the state SHALL stay DROP unless imem_rvalid, in which case it SHALL become REQ.
REQ-012 While if_valid=1 and stall=1, if_pc and if_instr SHALL be stable; redirect overrides stall.
REQ-013 When if_valid=1 and stall=0 with no new response, if_valid SHALL clear next cycle.
REQ-014 imem_rvalid in REQ or BOOT SHALL be ignored.
REQ-015 With imem_ready=1 and one-cycle read latency, throughput SHALL be one instruction per 2 cycles, and the first imem_req SHALL be in the 2nd cycle after reset release.

Reset
REQ-016 While rst=1, regardless of clk:
  state=BOOT, pc=RESET_PC, inflight_pc=RESET_PC.
  if_valid=0, if_pc=0, if_instr=NOP_INSTR.
  misaligned=0, imem_req=0.
REQ-017 Reset asserted mid-fetch SHALL abandon the outstanding request; any imem_rvalid arriving after reset release and before the first new request SHALL be ignored.

Verification
REQ-018 Directed scenarios the bench SHALL cover:
  Boot: rst released, ready=1, 1-cycle memory -> imem_addr sequence 0x0,0x4,0x8; if_pc follows one response later, each with if_valid=1.
  Taken branch in WAIT: br_valid=1, branch_taken=1, br_target=0x100, rvalid 2 cycles later -> that data dropped, next imem_addr=0x100, if_pc=0x100.
  Not-taken branch: br_valid=1, branch_taken=0 -> no flush, sequential PCs continue.
  Jump and taken branch same cycle: jump_target=0x200, br_target=0x300 -> fetch 0x200.
  Misaligned: jump_target=0x102 -> misaligned=1 for one cycle, PC stream unchanged.
  Stall: stall=1 for 3 cycles with if_valid=1 -> no imem_req, if_instr stable; on stall=0 fetch resumes at if_pc+4.
